reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 12 +
 rtl/reg_write_arbiter_if.sv | 10 +
 rtl/reg_write_arbiter_wb_fifo.sv | 61 ++++++
 rtl/reg_write_arbiter.sv | 60 ++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared register-file defines and helpers for the write arbiter.
package reg_write_arbiter_pkg;
  localparam int REGFILE_ADDRESS_LEN = 5;
  localparam int REGISTER_LEN = 32;
  localparam int REGISTER_MEM_SIZE = 32;
  typedef logic [REGFILE_ADDRESS_LEN-1:0] reg_addr_t;
  typedef logic [REGISTER_LEN-1:0] reg_data_t;
  typedef logic [REGISTER_MEM_SIZE-1:0] reg_mask_t;
  function automatic reg_mask_t dest_bit(reg_addr_t d);
    return reg_mask_t'(1) << d;
  endfunction
endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: one requester's write-request handshake into the arbiter.
interface reg_write_arbiter_if;
  import reg_write_arbiter_pkg::*;
  logic valid;
  reg_addr_t dest;
  reg_data_t data;
  logic ready;
  modport master (output valid, dest, data, input ready);
  modport slave (input valid, dest, data, output ready);
endinterface

// File: rtl/reg_write_arbiter_wb_fifo.sv
// wb_fifo: per-requester queue of (dest, data, stamp) with a mask of queued destinations.
module wb_fifo
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STAMP_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  reg_addr_t in_dest,
  input  reg_data_t in_data,
  input  logic [STAMP_W-1:0] in_stamp,
  output reg_addr_t head_dest,
  output reg_data_t head_data,
  output logic [STAMP_W-1:0] head_stamp,
  output logic full,
  output logic empty,
  output reg_mask_t dest_vec
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr, rd;
  logic [PW:0] cnt;
  reg_addr_t dest_mem [DEPTH];
  reg_data_t data_mem [DEPTH];
  logic [STAMP_W-1:0] stamp_mem [DEPTH];
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head_dest = dest_mem[rd];
  assign head_data = data_mem[rd];
  assign head_stamp = stamp_mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + PW'(push);
      rd <= rd + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr] <= in_dest;
      data_mem[wr] <= in_data;
      stamp_mem[wr] <= in_stamp;
    end
  end
  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    dest_vec = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd;
      if ({1'b0, off} < cnt) dest_vec = dest_vec | dest_bit(dest_mem[i]);
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges two register-file write streams, oldest accepted entry first.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STAMP_W = 3
) (
  input  logic clk,
  input  logic rst,
  reg_write_arbiter_if.slave a,
  reg_write_arbiter_if.slave b,
  output logic writeBackEn,
  output reg_addr_t Dest_wb,
  output reg_data_t Result_wb,
  output reg_mask_t pending_mask,
  output logic busy
);
  logic [STAMP_W-1:0] cnt, a_stamp, b_stamp, diff;
  logic a_full, b_full, a_empty, b_empty, a_push, b_push, a_grant, b_grant;
  reg_addr_t a_dest, b_dest;
  reg_data_t a_data, b_data;
  reg_mask_t a_vec, b_vec;
  assign a.ready = !a_full;
  assign b.ready = !b_full;
  assign a_push = a.valid && !a_full;
  assign b_push = b.valid && !b_full;
  // Modulo age compare: A is older when B's stamp is ahead by less than half the range.
  assign diff = b_stamp - a_stamp;
  assign a_grant = !a_empty && (b_empty || !diff[STAMP_W-1]);
  assign b_grant = !b_empty && !a_grant;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .STAMP_W(STAMP_W)) u_fifo_a (
    .clk(clk), .rst(rst), .push(a_push), .pop(a_grant),
    .in_dest(a.dest), .in_data(a.data), .in_stamp(cnt),
    .head_dest(a_dest), .head_data(a_data), .head_stamp(a_stamp),
    .full(a_full), .empty(a_empty), .dest_vec(a_vec)
  );
  wb_fifo #(.DEPTH(FIFO_DEPTH), .STAMP_W(STAMP_W)) u_fifo_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_grant),
    .in_dest(b.dest), .in_data(b.data), .in_stamp(cnt + STAMP_W'(a_push)),
    .head_dest(b_dest), .head_data(b_data), .head_stamp(b_stamp),
    .full(b_full), .empty(b_empty), .dest_vec(b_vec)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      writeBackEn <= 1'b0;
      Dest_wb <= '0;
      Result_wb <= '0;
    end else begin
      cnt <= cnt + STAMP_W'(a_push) + STAMP_W'(b_push);
      writeBackEn <= a_grant || b_grant;
      if (a_grant || b_grant) begin
        Dest_wb <= a_grant ? a_dest : b_dest;
        Result_wb <= a_grant ? a_data : b_data;
      end
    end
  end
  assign pending_mask = a_vec | b_vec | (writeBackEn ? dest_bit(Dest_wb) : '0);
  assign busy = !a_empty || !b_empty || writeBackEn;
endmodule
